// File: rtl/htif_responder.sv
// Host-target interface responder: TOHOST/FROMHOST/CONSOLE/STATUS register window with a console byte FIFO.
// Optional watchdog enabled by defining HTIF_TIMEOUT_EN.
module htif_responder #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_1000,
    parameter int          CON_DEPTH      = 8,
    parameter int          TIMEOUT_CYCLES = 5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        con_valid,
    input  logic        con_ready,
    output logic [7:0]  con_data,
    output logic        done,
    output logic        pass,
    output logic [30:0] fail_test,
    output logic        timeout
);

    localparam int AW = (CON_DEPTH > 1) ? $clog2(CON_DEPTH) : 1;

    logic        ready_en;
    logic [31:0] offset;
    logic [1:0]  reg_sel;
    logic        req_err;
    logic        accept;
    logic [31:0] tohost;
    logic [31:0] fromhost;
    logic [31:0] tohost_next;
    logic [31:0] fromhost_next;
    logic        tohost_wr;
    logic        tohost_set;
    logic        wd_fire;
    logic        overflow;
    logic [31:0] status;
    logic [31:0] rdata_c;

    logic [7:0]    mem [CON_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level;
    logic          full;
    logic          push_req;
    logic          push;
    logic          pop;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

    // Offset-based decode tolerates any BASE_ADDR, aligned or not.
    assign offset    = req_addr - BASE_ADDR;
    assign reg_sel   = offset[3:2];
    assign req_err   = (offset[31:4] != 28'd0) || (offset[1:0] != 2'd0) ||
                       (req_we && reg_sel == 2'd3);
    assign req_ready = ready_en && (!resp_valid || resp_ready);
    assign accept    = req_valid && req_ready;

    assign tohost_next   = merge_bytes(tohost, req_wdata, req_wstrb);
    assign fromhost_next = merge_bytes(fromhost, req_wdata, req_wstrb);
    assign tohost_wr     = accept && req_we && !req_err && reg_sel == 2'd0;
    assign tohost_set    = tohost_wr && !done && (tohost_next != 32'd0);

    assign full      = (level == (AW+1)'(CON_DEPTH));
    assign con_valid = (level != '0);
    assign con_data  = con_valid ? mem[rd_ptr] : 8'h00;
    assign pop       = con_valid && con_ready;
    assign push_req  = accept && req_we && !req_err && reg_sel == 2'd2 && req_wstrb[0];
    assign push      = push_req && (!full || pop);

    assign status = {16'h0000, 8'(level), 4'h0, overflow, timeout, pass, done};

    always_comb begin
        rdata_c = 32'd0;
        if (!req_err && !req_we) begin
            case (reg_sel)
                2'd0:    rdata_c = tohost;
                2'd1:    rdata_c = fromhost;
                2'd3:    rdata_c = status;
                default: rdata_c = 32'd0;
            endcase
        end
    end

    // Ready is held low through reset and comes up on the first edge after release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en   <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (accept) begin
                resp_valid <= 1'b1;
                resp_rdata <= rdata_c;
                resp_err   <= req_err;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tohost   <= 32'd0;
            fromhost <= 32'd0;
        end else if (accept && req_we && !req_err) begin
            if (reg_sel == 2'd0) tohost   <= tohost_next;
            if (reg_sel == 2'd1) fromhost <= fromhost_next;
        end
    end

    // Test status is sticky; a TOHOST verdict beats a watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_test <= 31'd0;
        end else if (tohost_set) begin
            done      <= 1'b1;
            pass      <= (tohost_next == 32'd1);
            fail_test <= (tohost_next == 32'd1) ? 31'd0 : tohost_next[31:1];
        end else if (wd_fire) begin
            done <= 1'b1;
            pass <= 1'b0;
        end
    end

`ifdef HTIF_TIMEOUT_EN
    logic [31:0] wd_cnt;

    assign wd_fire = !done && (wd_cnt == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt  <= 32'd0;
            timeout <= 1'b0;
        end else if (!done) begin
            if (wd_fire) begin
                timeout <= !tohost_set;
            end else begin
                wd_cnt <= wd_cnt + 32'd1;
            end
        end
    end
`else
    assign wd_fire = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      level <= level + 1'b1;
            else if (pop && !push) level <= level - 1'b1;
            if (push_req && full && !pop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= req_wdata[7:0];
    end

endmodule
